// File: rtl/zbt_pkg.sv
// rtl/zbt_pkg.sv - Shared types for the ZBT pixel packer and its word FIFO.
package zbt_pkg;

    localparam int ZBT_DATA_W = 36;
    localparam int ZBT_IDX_W  = 32;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACCUM,
        ST_FLUSH
    } packer_state_t;

    // The bank is captured at push time so a frame switch cannot retarget queued words.
    typedef struct packed {
        logic                  bank;
        logic [ZBT_IDX_W-1:0]  index;
        logic [ZBT_DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic fifo_entry_t make_entry(input logic                  bank,
                                               input logic [ZBT_IDX_W-1:0]  index,
                                               input logic [ZBT_DATA_W-1:0] data);
        fifo_entry_t e;
        e.bank  = bank;
        e.index = index;
        e.data  = data;
        return e;
    endfunction

endpackage

// File: rtl/zbt_wr_fifo.sv
// rtl/zbt_wr_fifo.sv - Synchronous word FIFO with occupancy output.
module zbt_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/zbt_pixel_packer.sv
// rtl/zbt_pixel_packer.sv - Packs pixels into 36-bit ZBT words and issues them on write slots.
// Define ZBT_PACKER_DBLBUF_EN to alternate frame banks; otherwise the bank bit stays 0.
module zbt_pixel_packer
    import zbt_pkg::*;
#(
    parameter int PIXEL_W      = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 19
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pix_valid,
    input  logic [X_W-1:0]                pix_x,
    input  logic [Y_W-1:0]                pix_y,
    input  logic [PIXEL_W-1:0]            pix_data,
    output logic                          pix_ready,
    input  logic                          frame_end,
    input  logic                          wr_slot,
    output logic                          zbt_we,
    output logic [ADDR_W-1:0]             zbt_addr,
    output logic [ZBT_DATA_W-1:0]         zbt_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_bank,
    output logic                          overflow
);

    localparam int LANE_W  = $clog2(PIX_PER_WORD);
    localparam int IDX_W   = Y_W + X_W - LANE_W;
    localparam int WORD_W  = PIXEL_W * PIX_PER_WORD;
    localparam int ENTRY_W = $bits(fifo_entry_t);

    packer_state_t           state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       acc_q, acc_d;
    logic [PIX_PER_WORD-1:0] mask_q, mask_d;
    logic                    bank_q, bank_d;
    logic                    overflow_q;
    logic                    zbt_we_q;
    logic [ADDR_W-1:0]       zbt_addr_q;
    logic [ZBT_DATA_W-1:0]   zbt_data_q;

    logic [IDX_W-1:0]        pix_idx;
    logic [LANE_W-1:0]       pix_lane;
    logic [PIX_PER_WORD-1:0] lane_oh;
    logic [WORD_W-1:0]       lane_bits;
    logic [WORD_W-1:0]       lane_keep;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    fifo_entry_t             push_entry;
    fifo_entry_t             head;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    unused_idx_hi;

    assign pix_idx   = {pix_y, pix_x[X_W-1:LANE_W]};
    assign pix_lane  = pix_x[LANE_W-1:0];
    assign lane_oh   = PIX_PER_WORD'(1) << pix_lane;
    assign lane_bits = WORD_W'(pix_data) << (32'(pix_lane) * PIXEL_W);
    assign lane_keep = ~(WORD_W'({PIXEL_W{1'b1}}) << (32'(pix_lane) * PIXEL_W));

    assign pix_ready = (state_q != ST_FLUSH) && !fifo_full;
    assign accept    = pix_valid && pix_ready;
    assign pop       = wr_slot && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        mask_d     = mask_q;
        bank_d     = bank_q;
        push       = 1'b0;
        push_entry = '0;
        if (state_q == ST_FLUSH) begin
            // Hold the flush while a pending word has nowhere to go.
            if (mask_q == '0 || !fifo_full || pop) begin
                if (mask_q != '0) begin
                    push       = 1'b1;
                    push_entry = make_entry(bank_q, ZBT_IDX_W'(idx_q), ZBT_DATA_W'(acc_q));
                end
                mask_d  = '0;
                acc_d   = '0;
                state_d = ST_EMPTY;
`ifdef ZBT_PACKER_DBLBUF_EN
                bank_d  = ~bank_q;
`else
                bank_d  = 1'b0;
`endif
            end
        end else begin
            if (accept) begin
                if (state_q == ST_ACCUM && pix_idx == idx_q) begin
                    acc_d  = (acc_q & lane_keep) | lane_bits;
                    mask_d = mask_q | lane_oh;
                end else begin
                    if (state_q == ST_ACCUM) begin
                        push       = 1'b1;
                        push_entry = make_entry(bank_q, ZBT_IDX_W'(idx_q), ZBT_DATA_W'(acc_q));
                    end
                    idx_d  = pix_idx;
                    acc_d  = lane_bits;
                    mask_d = lane_oh;
                end
                state_d = ST_ACCUM;
                if (&mask_d) begin
                    push       = 1'b1;
                    push_entry = make_entry(bank_q, ZBT_IDX_W'(idx_d), ZBT_DATA_W'(acc_d));
                    mask_d     = '0;
                    acc_d      = '0;
                    state_d    = ST_EMPTY;
                end
            end
            if (frame_end) state_d = ST_FLUSH;
        end
    end

    zbt_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_entry),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head          = fifo_rdata;
    assign unused_idx_hi = ^head.index[ZBT_IDX_W-1:ADDR_W-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            idx_q      <= '0;
            acc_q      <= '0;
            mask_q     <= '0;
            bank_q     <= 1'b0;
            overflow_q <= 1'b0;
            zbt_we_q   <= 1'b0;
            zbt_addr_q <= '0;
            zbt_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            mask_q     <= mask_d;
            bank_q     <= bank_d;
            overflow_q <= overflow_q | (pix_valid & ~pix_ready);
            zbt_we_q   <= pop;
            if (pop) begin
                zbt_addr_q <= {head.bank, head.index[ADDR_W-2:0]};
                zbt_data_q <= head.data;
            end
        end
    end

    assign zbt_we   = zbt_we_q;
    assign zbt_addr = zbt_addr_q;
    assign zbt_data = zbt_data_q;
    assign wr_bank  = bank_q;
    assign overflow = overflow_q;

endmodule
